move_scheduler: RTL and testbench

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/move_scheduler_pkg.sv | 29 ++
 rtl/move_scheduler_if.sv | 29 ++
 rtl/move_scheduler_gravity_timer.sv | 57 +++++
 rtl/move_scheduler.sv | 151 +++++++++++++++
 tb/tb_move_scheduler.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/move_scheduler_pkg.sv
// Package tetris: types and constants shared by the move scheduler slice.
//   direction_e      - move direction; eDown encodes as 0 so a reset bus reads all-zero
//   sched_state_e    - move scheduler FSM states
//   move_src_e       - origin of the move currently in flight
//   GravityPeriodDflt- default clock cycles between gravity ticks
package tetris;

  typedef enum logic [1:0] {
    eDown   = 2'd0,
    eLeft   = 2'd1,
    eRight  = 2'd2,
    eRotate = 2'd3
  } direction_e;

  typedef enum logic [1:0] {
    eIDLE  = 2'd0,
    eISSUE = 2'd1,
    eWAIT  = 2'd2,
    eLOCK  = 2'd3
  } sched_state_e;

  typedef enum logic {
    eSrcGravity = 1'b0,
    eSrcKey     = 1'b1
  } move_src_e;

  localparam int unsigned GravityPeriodDflt = 50_000_000;

endpackage

// File: rtl/move_scheduler_if.sv
// Handshake bundle between the move scheduler and its environment
// (keyboard front end, move executor, lock/respawn logic).
//   slave  : scheduler view (consumes key/executor/lock inputs, drives requests)
//   master : environment view (drives key/executor/lock inputs)
interface move_scheduler_if;
  import tetris::*;

  logic       key_v_i;
  direction_e key_dir_i;
  logic       key_ready_o;
  logic       exe_v_o;
  direction_e exe_dir_o;
  logic       exe_ready_i;
  logic       exe_pos_v_i;
  logic       moved_o;
  logic       lock_v_o;
  logic       lock_done_i;

  modport slave (
    input  key_v_i, key_dir_i, exe_ready_i, exe_pos_v_i, lock_done_i,
    output key_ready_o, exe_v_o, exe_dir_o, moved_o, lock_v_o
  );

  modport master (
    output key_v_i, key_dir_i, exe_ready_i, exe_pos_v_i, lock_done_i,
    input  key_ready_o, exe_v_o, exe_dir_o, moved_o, lock_v_o
  );

endinterface

// File: rtl/move_scheduler_gravity_timer.sv
// gravity_timer: free-running gravity counter with a sticky tick-pending flag.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   enable_i        : count this cycle
//   clear_i         : zero the counter and drop the pending flag (highest priority)
//   ack_i           : the pending tick has been consumed
//   pending_o       : a gravity tick is waiting to be issued
module gravity_timer #(
  parameter int unsigned period_p = 8
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic enable_i,
  input  logic clear_i,
  input  logic ack_i,
  output logic pending_o
);

  localparam int unsigned CntW = (period_p > 1) ? $clog2(period_p) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(period_p - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pending_q, pending_d;

  // A fresh terminal count overrides an ack in the same cycle so the new
  // tick is not lost; ticks never stack beyond one.
  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    if (clear_i) begin
      cnt_d     = '0;
      pending_d = 1'b0;
    end else begin
      if (ack_i) pending_d = 1'b0;
      if (enable_i) begin
        if (cnt_q == TermCnt) begin
          cnt_d     = '0;
          pending_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: arbitrates gravity ticks and user key moves into single
// requests to the move executor, reports success and requests tile locks.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   game_en_i       : play active; low holds the gravity counter at zero
//   bus_if (slave)  : key request, executor request/response, moved/lock pulses
// Parameter gravity_period_p: cycles between gravity ticks (>= 2).
// Build option: define MOVE_SCHEDULER_SOFT_DROP_EN to execute key eDown as a
// soft drop; otherwise a key eDown is accepted and discarded.
module move_scheduler
  import tetris::*;
#(
  parameter int unsigned gravity_period_p = GravityPeriodDflt
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    game_en_i,
  move_scheduler_if.slave         bus_if
);

  sched_state_e state_q, state_d;
  move_src_e    src_q, src_d;
  direction_e   dir_q, dir_d;
  logic         success_q, success_d;

  logic tick_pending;
  logic tmr_enable, tmr_clear, tmr_ack;
  logic key_ready, moved, lock_v;
  logic success_now, lock_on_fail, soft_drop_hit;

  gravity_timer #(
    .period_p (gravity_period_p)
  ) u_gravity_timer (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .enable_i  (tmr_enable),
    .clear_i   (tmr_clear),
    .ack_i     (tmr_ack),
    .pending_o (tick_pending)
  );

  // A position pulse coincident with the exit cycle still counts as success.
  assign success_now = success_q | bus_if.exe_pos_v_i;

`ifdef MOVE_SCHEDULER_SOFT_DROP_EN
  assign lock_on_fail  = (src_q == eSrcGravity) || (dir_q == eDown);
  assign soft_drop_hit = (src_q == eSrcKey) && (dir_q == eDown);
`else
  assign lock_on_fail  = (src_q == eSrcGravity);
  assign soft_drop_hit = 1'b0;
`endif

  assign tmr_enable = game_en_i && (state_q != eLOCK);

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dir_d     = dir_q;
    success_d = success_q;
    tmr_clear = !game_en_i;
    tmr_ack   = 1'b0;
    key_ready = 1'b0;
    moved     = 1'b0;
    lock_v    = 1'b0;

    unique case (state_q)
      eIDLE: begin
        if (game_en_i) begin
          if (tick_pending) begin
            state_d   = eISSUE;
            src_d     = eSrcGravity;
            dir_d     = eDown;
            success_d = 1'b0;
            tmr_ack   = 1'b1;
          end else begin
            key_ready = 1'b1;
            if (bus_if.key_v_i) begin
`ifdef MOVE_SCHEDULER_SOFT_DROP_EN
              state_d   = eISSUE;
              src_d     = eSrcKey;
              dir_d     = bus_if.key_dir_i;
              success_d = 1'b0;
`else
              // Key eDown is handshaken but dropped here.
              if (bus_if.key_dir_i != eDown) begin
                state_d   = eISSUE;
                src_d     = eSrcKey;
                dir_d     = bus_if.key_dir_i;
                success_d = 1'b0;
              end
`endif
            end
          end
        end
      end

      eISSUE: begin
        if (bus_if.exe_ready_i) state_d = eWAIT;
      end

      eWAIT: begin
        if (bus_if.exe_pos_v_i) success_d = 1'b1;
        if (bus_if.exe_ready_i) begin
          success_d = 1'b0;
          if (success_now) begin
            moved   = 1'b1;
            state_d = eIDLE;
            if (soft_drop_hit) tmr_clear = 1'b1;
          end else if (lock_on_fail) begin
            lock_v  = 1'b1;
            state_d = eLOCK;
          end else begin
            state_d = eIDLE;
          end
        end
      end

      eLOCK: begin
        if (bus_if.lock_done_i) begin
          state_d   = eIDLE;
          tmr_clear = 1'b1;
        end
      end

      default: state_d = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= eIDLE;
      src_q     <= eSrcGravity;
      dir_q     <= eDown;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dir_q     <= dir_d;
      success_q <= success_d;
    end
  end

  // exe_v/exe_dir decode registered state; moved/lock pulse in the exit cycle
  // itself, so they are qualified by state rather than registered.
  // key_ready is gated by reset because eIDLE is also the reset state.
  assign bus_if.exe_v_o     = (state_q == eISSUE);
  assign bus_if.exe_dir_o   = dir_q;
  assign bus_if.key_ready_o = key_ready & reset_ni;
  assign bus_if.moved_o     = moved;
  assign bus_if.lock_v_o    = lock_v;

endmodule

// File: tb/tb_move_scheduler.sv
module tb_move_scheduler;
  import tetris::*;

  localparam int unsigned Period = 8;

  logic clk_i = 1'b0;
  logic reset_ni;
  logic game_en_i;

  move_scheduler_if bus_if ();

  move_scheduler #(
    .gravity_period_p (Period)
  ) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .game_en_i (game_en_i),
    .bus_if    (bus_if)
  );

  always #5 clk_i = ~clk_i;

  // kind: 0 = executor handshake, 1 = moved pulse, 2 = lock pulse
  typedef struct {
    int         kind;
    direction_e dir;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  last_hs = -1;
  bit  chk_period = 1'b0;
  bit  exe_succeed = 1'b1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic push(input int kind, input direction_e d);
    ev_t e;
    e.kind = kind;
    e.dir  = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input direction_e d);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d dir %0d want none", kind, int'(d));
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == 0 && e.kind == 0) check("issue_dir", int'(d), int'(e.dir));
    end
  endtask

  // Monitor: samples on the falling edge, scoreboards every DUT event.
  initial begin
    forever begin
      @(negedge clk_i);
      if (reset_ni === 1'b1) begin
        cyc++;
        if (bus_if.exe_v_o && bus_if.exe_ready_i) begin
          if (chk_period && last_hs >= 0) check("gravity_period", cyc - last_hs, int'(Period));
          last_hs = cyc;
          observe(0, bus_if.exe_dir_o);
        end
        if (bus_if.moved_o)  observe(1, eDown);
        if (bus_if.lock_v_o) observe(2, eDown);
      end
    end
  end

  // Executor model: busy two cycles after a handshake, optional position pulse.
  initial begin
    bus_if.exe_ready_i = 1'b1;
    bus_if.exe_pos_v_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (bus_if.exe_v_o && bus_if.exe_ready_i) begin
        @(posedge clk_i); #1;
        bus_if.exe_ready_i = 1'b0;
        @(posedge clk_i); #1;
        bus_if.exe_pos_v_i = exe_succeed;
        @(posedge clk_i); #1;
        bus_if.exe_pos_v_i = 1'b0;
        bus_if.exe_ready_i = 1'b1;
      end
    end
  end

  task automatic send_key(input direction_e d, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    bus_if.key_v_i   = 1'b1;
    bus_if.key_dir_i = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (bus_if.key_ready_o) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL key_accept_timeout: got key_ready_o low want accept");
    end
    @(posedge clk_i); #1;
    bus_if.key_v_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d outstanding events want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic cycles_to_exe_v(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      n++;
      @(negedge clk_i);
      if (bus_if.exe_v_o) break;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_key_ready"}, int'(bus_if.key_ready_o), 0);
    check({tag, "_exe_v"},     int'(bus_if.exe_v_o), 0);
    check({tag, "_exe_dir"},   int'(bus_if.exe_dir_o), int'(eDown));
    check({tag, "_moved"},     int'(bus_if.moved_o), 0);
    check({tag, "_lock_v"},    int'(bus_if.lock_v_o), 0);
  endtask

  initial begin
    int w;
    int n;
    bit fl_exe;
    bit fl_key;

    reset_ni           = 1'b1;
    game_en_i          = 1'b0;
    bus_if.key_v_i     = 1'b0;
    bus_if.key_dir_i   = eLeft;
    bus_if.lock_done_i = 1'b0;
    #2;
    reset_ni  = 1'b0;
    game_en_i = 1'b1;
    #10;
    check_outputs_zero("reset");

    game_en_i = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(posedge clk_i); #1;
    check("disabled_key_ready", int'(bus_if.key_ready_o), 0);

    // Gravity only: eDown every Period cycles, each one moved.
    exe_succeed = 1'b1;
    last_hs     = -1;
    chk_period  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(0, eDown);
      push(1, eDown);
    end
    game_en_i = 1'b1;
    drain(60);
    chk_period = 1'b0;
    game_en_i  = 1'b0;
    @(posedge clk_i); #1;

    // Single key eLeft while idle.
    push(0, eLeft);
    push(1, eDown);
    game_en_i = 1'b1;
    send_key(eLeft, w);
    check("key_idle_wait", w, 0);
    check("key_ready_busy", int'(bus_if.key_ready_o), 0);
    drain(30);
    game_en_i = 1'b0;
    @(posedge clk_i); #1;

    // Gravity tick and key in the same cycle: gravity first, key held.
    push(0, eDown);
    push(1, eDown);
    push(0, eRight);
    push(1, eDown);
    game_en_i = 1'b1;
    repeat (Period) @(posedge clk_i);
    #1;
    send_key(eRight, w);
    check("key_held_behind_gravity", w, 5);
    game_en_i = 1'b0;
    drain(30);
    @(posedge clk_i); #1;

    // Gravity move rejected: lock, frozen until lock_done.
    exe_succeed = 1'b0;
    push(0, eDown);
    push(2, eDown);
    game_en_i = 1'b1;
    drain(40);
    fl_exe = 1'b0;
    fl_key = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (bus_if.exe_v_o)     fl_exe = 1'b1;
      if (bus_if.key_ready_o) fl_key = 1'b1;
    end
    check("lock_exe_v_quiet", int'(fl_exe), 0);
    check("lock_key_ready_quiet", int'(fl_key), 0);
    bus_if.lock_done_i = 1'b1;
    @(posedge clk_i); #1;
    bus_if.lock_done_i = 1'b0;
    exe_succeed = 1'b1;
    push(0, eDown);
    push(1, eDown);
    cycles_to_exe_v(n);
    check("post_lock_first_issue", n, 9);
    drain(30);
    game_en_i = 1'b0;
    @(posedge clk_i); #1;

    // Key eDown with a rejecting executor.
    exe_succeed = 1'b0;
    game_en_i   = 1'b1;
`ifdef MOVE_SCHEDULER_SOFT_DROP_EN
    push(0, eDown);
    push(2, eDown);
    send_key(eDown, w);
    check("soft_drop_wait", w, 0);
    drain(30);
    @(negedge clk_i);
    bus_if.lock_done_i = 1'b1;
    @(posedge clk_i); #1;
    bus_if.lock_done_i = 1'b0;
`else
    send_key(eDown, w);
    check("discard_wait", w, 0);
    fl_exe = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (bus_if.exe_v_o) fl_exe = 1'b1;
    end
    check("discard_no_exe_v", int'(fl_exe), 0);
    check("discard_key_ready_back", int'(bus_if.key_ready_o), 1);
`endif
    game_en_i   = 1'b0;
    exe_succeed = 1'b1;
    @(posedge clk_i); #1;

    // Reset dropped while waiting on the executor.
    push(0, eLeft);
    game_en_i = 1'b1;
    send_key(eLeft, w);
    @(posedge clk_i); #2;
    reset_ni = 1'b0;
    #1;
    check_outputs_zero("midop_reset");
    repeat (3) @(negedge clk_i);
    check_outputs_zero("reset_hold");
    reset_ni = 1'b1;
    push(0, eDown);
    push(1, eDown);
    cycles_to_exe_v(n);
    check("post_reset_first_issue", n, 9);
    drain(30);
    game_en_i = 1'b0;

    repeat (5) @(negedge clk_i);
    check("leftover_events", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
